// File: rtl/bcnn_layer2_scheduler.sv
// rtl/bcnn_layer2_scheduler.sv - layer-2 binary conv scheduler: frame capture, per-filter replay, binarized output
// Optional BCNN_THRESH_ROM_EN: per-filter threshold read from the weight ROM instead of THRESH.
module bcnn_layer2_scheduler #(
  parameter int IMG_WIDTH     = 13,
  parameter int IMG_HEIGHT    = 13,
  parameter int KERNEL_SIZE   = 3,
  parameter int SUM_WIDTH     = 4,
  parameter int NUM_FILTERS   = 4,
  parameter int THRESH        = 5,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int KK      = KERNEL_SIZE * KERNEL_SIZE,
  localparam int OUT_PIX = (IMG_WIDTH - KERNEL_SIZE + 1) * (IMG_HEIGHT - KERNEL_SIZE + 1),
  localparam int FW      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int IW      = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_pixel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FW-1:0]        w_addr,
  input  logic [KK-1:0]        w_data,
`ifdef BCNN_THRESH_ROM_EN
  input  logic [SUM_WIDTH-1:0] w_thresh,
`endif
  output logic                 dp_pixel,
  output logic                 dp_valid,
  output logic [KK-1:0]        dp_weight,
  output logic                 dp_flush,
  input  logic [SUM_WIDTH-1:0] dp_popcount,
  input  logic                 dp_valid_out,
  output logic                 out_bit,
  output logic [FW-1:0]        out_filter,
  output logic [IW-1:0]        out_index,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int CW   = $clog2(OUT_PIX + 1);
  localparam int DW   = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_FETCH, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t               state, state_nx;
  logic                 frame_buf [NPIX];
  logic [PW-1:0]        ld_ptr, ptr;
  logic [CW-1:0]        out_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [FW-1:0]        filt;
  logic [KK-1:0]        wreg;
  logic                 fetch_ph;
  logic [SUM_WIDTH-1:0] thr;
  logic                 accept, last_out, timeout, load_last, stream_last, last_filt;

  assign accept      = dp_valid_out && (state == S_STREAM || state == S_DRAIN) && (out_cnt < CW'(OUT_PIX));
  // Completion is recognised in the same cycle the final output is latched.
  assign last_out    = (out_cnt == CW'(OUT_PIX)) || (accept && out_cnt == CW'(OUT_PIX - 1));
  assign timeout     = drain_cnt == DW'(DRAIN_TIMEOUT - 1);
  assign load_last   = in_valid && (ld_ptr == PW'(NPIX - 1));
  assign stream_last = ptr == PW'(NPIX - 1);
  assign last_filt   = filt == FW'(NUM_FILTERS - 1);
  assign dp_weight   = wreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   if (load_last) state_nx = S_FLUSH;
      S_FLUSH:  state_nx = S_FETCH;
      S_FETCH:  if (fetch_ph) state_nx = S_STREAM;
      S_STREAM: if (stream_last) state_nx = S_DRAIN;
      S_DRAIN:  if (last_out || timeout) state_nx = last_filt ? S_DONE : S_FLUSH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    dp_flush = 1'b0;
    dp_valid = 1'b0;
    dp_pixel = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOAD:   in_ready = 1'b1;
      S_FLUSH:  dp_flush = 1'b1;
      S_STREAM: begin
        dp_valid = 1'b1;
        dp_pixel = frame_buf[ptr];
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Frame buffer is retained across frames, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) frame_buf[ld_ptr] <= in_pixel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_ptr     <= '0;
      ptr        <= '0;
      out_cnt    <= '0;
      drain_cnt  <= '0;
      filt       <= '0;
      wreg       <= '0;
      fetch_ph   <= 1'b0;
      w_addr     <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_filter <= '0;
      out_index  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          err    <= 1'b0;
          filt   <= '0;
          ld_ptr <= '0;
        end
        S_LOAD: if (in_valid) ld_ptr <= ld_ptr + 1'b1;
        S_FLUSH: begin
          ptr       <= '0;
          out_cnt   <= '0;
          drain_cnt <= '0;
          fetch_ph  <= 1'b0;
          w_addr    <= filt;
        end
        S_FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) wreg <= w_data;
        end
        S_STREAM: ptr <= ptr + 1'b1;
        S_DRAIN: begin
          if (last_out || timeout) begin
            if (!last_out) err <= 1'b1;
            if (!last_filt) filt <= filt + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        out_valid  <= 1'b1;
        out_bit    <= (dp_popcount >= thr);
        out_filter <= filt;
        out_index  <= IW'(out_cnt);
        out_cnt    <= out_cnt + 1'b1;
      end
    end
  end

`ifdef BCNN_THRESH_ROM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           thr <= '0;
    else if (state == S_FETCH && fetch_ph) thr <= w_thresh;
  end
`else
  assign thr = SUM_WIDTH'(THRESH);
`endif

endmodule

// File: tb/tb_bcnn_layer2_scheduler.sv
// tb/tb_bcnn_layer2_scheduler.sv - scoreboard bench for bcnn_layer2_scheduler with ROM and ideal datapath models
module tb_bcnn_layer2_scheduler;
  localparam int W       = 13;
  localparam int NPIX    = 169;
  localparam int OW      = 11;
  localparam int OUT_PIX = 121;
  localparam int NF      = 4;
  localparam int THR     = 5;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, in_pixel = 1'b0, in_valid = 1'b0;
  logic       in_ready, dp_pixel, dp_valid, dp_flush, out_bit, out_valid, busy, done, err;
  logic [1:0] w_addr, out_filter;
  logic [8:0] w_data = '0;
  logic [8:0] dp_weight;
  logic [3:0] dp_popcount = '0;
  logic       dp_valid_out = 1'b0;
  logic [6:0] out_index;

  bcnn_layer2_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data), .dp_pixel(dp_pixel),
    .dp_valid(dp_valid), .dp_weight(dp_weight), .dp_flush(dp_flush),
    .dp_popcount(dp_popcount), .dp_valid_out(dp_valid_out), .out_bit(out_bit),
    .out_filter(out_filter), .out_index(out_index), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [NF];
  always @(posedge clk) w_data <= rom[w_addr];

  // Ideal datapath: popcount of (window & weights) for every full 3x3 window, one cycle late.
  logic mpix [NPIX];
  int   m_in = 0, m_nout = 0, m_flush = 0, lim_flush = -1, lim_n = 0;
  always @(posedge clk) begin
    int r, c, pc;
    dp_valid_out <= 1'b0;
    if (dp_flush) begin
      m_in = 0;
      m_nout = 0;
      m_flush++;
    end
    if (dp_valid && m_in < NPIX) begin
      mpix[m_in] = dp_pixel;
      r = m_in / W;
      c = m_in % W;
      if (r >= 2 && c >= 2 && !(m_flush == lim_flush && m_nout >= lim_n)) begin
        pc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            pc += int'(mpix[(r - 2 + i) * W + c - 2 + j] & dp_weight[i * 3 + j]);
        dp_popcount  <= 4'(pc);
        dp_valid_out <= 1'b1;
        m_nout++;
      end
      m_in++;
    end
  end

  typedef struct packed {
    logic [1:0] f;
    logic [6:0] idx;
    logic       b;
  } exp_t;
  exp_t sbq[$];
  logic frame [NPIX];
  int   n_pass = 0, n_total = 0;
  int   flush_cnt, done_cnt, n_out;
  logic err_after_start;

  task automatic push_expected(input int limit_f, input int limit_n);
    int pc;
    exp_t e;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < OW; r++)
        for (int c = 0; c < OW; c++) begin
          if (f == limit_f && r * OW + c >= limit_n) continue;
          pc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              pc += int'(frame[(r + i) * W + c + j] & rom[f][i * 3 + j]);
          e.f = 2'(f);
          e.idx = 7'(r * OW + c);
          e.b = (pc >= THR);
          sbq.push_back(e);
        end
  endtask

  task automatic load_frame(input bit gapped);
    int  i = 0;
    int  cyc = 0;
    bit  tog = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (i < NPIX && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) err_after_start = err;
      if (gapped && tog) in_valid = 1'b0;
      else if (in_ready) begin
        in_valid = 1'b1;
        in_pixel = frame[i];
        i++;
      end else in_valid = 1'b0;
      tog = !tog;
    end
    n_total++;
    if (i != NPIX) $display("FAIL load_accept: accepted %0d required %0d", i, NPIX);
    else n_pass++;
  endtask

  task automatic collect(input bit poke);
    bit   finished = 1'b0;
    bit   prev_flush = 1'b0;
    int   pokes = 0;
    exp_t e;
    flush_cnt = 0;
    done_cnt = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start = poke && dp_valid && !start && pokes < 3;
      if (start) pokes++;
      if (cyc == 0) begin
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL in_ready_drop: got %b required 0", in_ready);
        else n_pass++;
      end
      if (prev_flush) begin
        n_total++;
        if (w_addr !== 2'(flush_cnt - 1)) $display("FAIL w_addr: got %0d required %0d", w_addr, flush_cnt - 1);
        else n_pass++;
      end
      prev_flush = dp_flush;
      if (dp_flush) flush_cnt++;
      if (out_valid) begin
        n_out++;
        n_total++;
        if (sbq.size() == 0) $display("FAIL extra_output: got f%0d i%0d required none", out_filter, out_index);
        else begin
          e = sbq.pop_front();
          if ({out_filter, out_index, out_bit} !== e)
            $display("FAIL out_stream: got f%0d i%0d b%b required f%0d i%0d b%b",
                     out_filter, out_index, out_bit, e.f, e.idx, e.b);
          else n_pass++;
        end
      end
      if (done) begin
        done_cnt++;
        finished = 1'b1;
      end
    end
    start = 1'b0;
    n_total++;
    if (!finished) $display("FAIL done_timeout: got no done required done");
    else n_pass++;
    n_total++;
    if (sbq.size() != 0) $display("FAIL missing_outputs: got %0d left required 0", sbq.size());
    else n_pass++;
    sbq.delete();
  endtask

  task automatic run_uniform(input bit pix, input logic [8:0] wv, input bit expect_one);
    for (int i = 0; i < NPIX; i++) frame[i] = pix;
    for (int f = 0; f < NF; f++) rom[f] = wv;
    push_expected(-1, 0);
    load_frame(1'b0);
    collect(1'b0);
    n_total++;
    if (n_out != NF * OUT_PIX) $display("FAIL out_count: got %0d required %0d", n_out, NF * OUT_PIX);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL err_clean: got %b required 0", err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL done_single: got %b required 00", {done, busy});
    else n_pass++;
    if (expect_one) begin
      n_total++;
      if (flush_cnt != NF) $display("FAIL flush_count: got %0d required %0d", flush_cnt, NF);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++;
    if ({in_ready, dp_valid, dp_flush, dp_pixel, out_valid, out_bit, busy, done, err,
         w_addr, dp_weight, out_filter, out_index} !== '0)
      $display("FAIL reset_outputs: got nonzero required all zero");
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: got busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_all_ones;
    run_uniform(1'b1, 9'h1FF, 1'b1);
  endtask

  task automatic test_zero_weights;
    run_uniform(1'b1, 9'h000, 1'b0);
  endtask

  task automatic test_alternating_weights;
    for (int i = 0; i < NPIX; i++) frame[i] = 1'b1;
    rom[0] = 9'h1FF; rom[1] = 9'h000; rom[2] = 9'h1FF; rom[3] = 9'h000;
    push_expected(-1, 0);
    load_frame(1'b0);
    collect(1'b0);
    n_total++;
    if (flush_cnt != NF) $display("FAIL alt_flush_count: got %0d required %0d", flush_cnt, NF);
    else n_pass++;
  endtask

  task automatic test_random(input bit gapped);
    push_expected(-1, 0);
    load_frame(gapped);
    collect(gapped);
    n_total++;
    if (n_out != NF * OUT_PIX || done_cnt != 1)
      $display("FAIL random_frame: got %0d outputs %0d done required %0d outputs 1 done", n_out, done_cnt, NF * OUT_PIX);
    else n_pass++;
  endtask

  task automatic test_drain_timeout;
    lim_flush = m_flush + 2;
    lim_n = 100;
    push_expected(1, 100);
    load_frame(1'b0);
    collect(1'b0);
    lim_flush = -1;
    n_total++;
    if (err !== 1'b1 || done_cnt != 1) $display("FAIL timeout_err: got err=%b done=%0d required err=1 done=1", err, done_cnt);
    else n_pass++;
    n_total++;
    if (n_out != 3 * OUT_PIX + 100) $display("FAIL timeout_count: got %0d required %0d", n_out, 3 * OUT_PIX + 100);
    else n_pass++;
    push_expected(-1, 0);
    load_frame(1'b0);
    n_total++;
    if (err_after_start !== 1'b0) $display("FAIL err_clear: got %b required 0", err_after_start);
    else n_pass++;
    collect(1'b0);
  endtask

  task automatic test_reset_mid_stream;
    int fl = 0;
    int sv = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = 1'b1;
    for (int f = 0; f < NF; f++) rom[f] = 9'h1FF;
    load_frame(1'b0);
    for (int cyc = 0; cyc < 3000 && sv < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (dp_flush) fl++;
      if (fl == 3 && dp_valid) sv++;
    end
    n_total++;
    if (sv < 20) $display("FAIL abort_reach: got %0d stream cycles required 20", sv);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({in_ready, dp_valid, dp_flush, dp_pixel, out_valid, out_bit, busy, done, err,
         w_addr, dp_weight, out_filter, out_index} !== '0)
      $display("FAIL async_reset: got nonzero outputs required all zero");
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    run_uniform(1'b1, 9'h1FF, 1'b1);
  endtask

  initial begin
    for (int f = 0; f < NF; f++) rom[f] = '0;
    test_reset();
    test_all_ones();
    test_zero_weights();
    test_alternating_weights();
    for (int i = 0; i < NPIX; i++) frame[i] = 1'($urandom_range(0, 1));
    for (int f = 0; f < NF; f++) rom[f] = 9'($urandom);
    test_random(1'b0);
    test_random(1'b1);
    test_drain_timeout();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcnn_layer2_scheduler.md
Name: bcnn_layer2_scheduler

Overview:
- Sequences one binary 3x3 conv datapath (patch extractor plus systolic popcount chain) across NUM_FILTERS output filters for a layer-2 feature map.
- Captures one IMG_WIDTH x IMG_HEIGHT binary frame into an internal bit buffer, then replays it once per filter with that filter's weights.
- Binarizes each returned popcount against a threshold and emits a tagged output bit stream.
- Sits between the layer-1 output stream, the weight ROM and the conv datapath.

Parameters:
- IMG_WIDTH, 13, frame width in pixels
- IMG_HEIGHT, 13, frame height in pixels
- KERNEL_SIZE, 3, kernel edge
- SUM_WIDTH, 4, datapath popcount width
- NUM_FILTERS, 4, filters per frame
- THRESH, 5, binarization threshold: out_bit = (popcount >= THRESH)
- DRAIN_TIMEOUT, 64, maximum cycles allowed in DRAIN

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a frame when idle
- in_pixel  in  1  input frame bit, raster order
- in_valid  in  1  in_pixel valid
- in_ready  out  1  scheduler accepts in_pixel
- w_addr  out  clog2(NUM_FILTERS)  weight ROM address (filter index)
- w_data  in  KERNEL_SIZE^2  weight ROM data; 1-cycle synchronous read latency
- dp_pixel  out  1  pixel to datapath
- dp_valid  out  1  pixel valid to datapath
- dp_weight  out  KERNEL_SIZE^2  weights to datapath, held constant per filter
- dp_flush  out  1  one-cycle datapath clear pulse, active-high
- dp_popcount  in  SUM_WIDTH  datapath result
- dp_valid_out  in  1  dp_popcount valid
- out_bit  out  1  binarized result
- out_filter  out  clog2(NUM_FILTERS)  filter tag
- out_index  out  clog2(OUT_PIX)  raster index within the output map, where OUT_PIX = (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1), 121 at defaults
- out_valid  out  1  out_* valid, single-cycle qualifier
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the frame completes
- err  out  1  sticky drain-timeout flag; cleared on the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state returns to IDLE. All counters, the filter index and the weight register clear. All outputs are 0.
- States: IDLE, LOAD, FLUSH, FETCH, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 moves to LOAD, clears err and the filter index.
  - in_ready=0; in_valid is ignored.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. Each cycle with in_valid=1 writes buf[ld_ptr] and increments ld_ptr.
  - Gaps in in_valid stall LOAD with no loss.
  - After bit IMG_WIDTH*IMG_HEIGHT-1 (168) is accepted, move to FLUSH; in_ready drops in the following cycle.
- FLUSH: dp_flush=1 for exactly one cycle, then move to FETCH. Also clears the pixel pointer and the output counter.
- FETCH (2 cycles):
  - Cycle 1 drives w_addr = filter index.
  - Cycle 2 latches w_data into the weight register, then moves to STREAM.
  - w_addr holds the filter index until the next FETCH.
- STREAM:
  - dp_valid=1 for exactly IMG_WIDTH*IMG_HEIGHT consecutive cycles, with dp_pixel = buf[ptr] and ptr running 0..168.
  - Then move to DRAIN.
  - dp_weight equals the weight register throughout STREAM and DRAIN.
- Output path (active in STREAM and DRAIN):
  - Each dp_valid_out=1 produces, on the next clock, out_valid=1 with out_bit = (dp_popcount >= THRESH), out_filter = current filter and out_index = out_cnt.
  - out_cnt then increments.
  - dp_valid_out in any other state is dropped.
  - dp_valid_out beyond OUT_PIX per filter is dropped.
- DRAIN:
  - Wait until out_cnt == OUT_PIX; the exit check happens at the latch cycle of the final output.
  - If DRAIN_TIMEOUT cycles elapse first, set err and advance anyway.
  - On advance: if filter == NUM_FILTERS-1, go to DONE; otherwise increment the filter index and go to FLUSH.
- DONE: done=1 for one cycle, then IDLE. The image buffer is retained but not reused.
- Comparison is unsigned at SUM_WIDTH bits. THRESH=0 makes every output bit 1.

Optional Feature:
- Macro: BCNN_THRESH_ROM_EN
- Defined:
  - Adds input w_thresh [SUM_WIDTH], read with the same address and latency as w_data and latched in FETCH cycle 2.
  - out_bit = (dp_popcount >= latched w_thresh). The THRESH parameter is unused.
- Undefined: no w_thresh port; THRESH parameter applies to every filter.

Test Plan:
- All-ones frame, w_data=9'h1FF for all filters, ideal datapath model -> 484 out_valid pulses, all out_bit=1; out_filter 0..3 with out_index 0..120 each; one done pulse; err=0.
- All-ones frame, w_data=9'h000 -> popcount 0 -> all 484 out_bit=0.
- Weights per filter {9'h1FF, 9'h000, 9'h1FF, 9'h000} with popcounts 9/0 -> out_bit pattern 1,0,1,0 by filter; w_addr sequence 0,1,2,3; exactly one dp_flush before each filter (4 total).
- in_valid asserted only on alternate cycles during LOAD -> all 169 bits captured correctly, identical results to the contiguous load; start pulses during STREAM have no effect.
- Datapath model returns only 100 outputs for filter 1 -> err set after DRAIN_TIMEOUT cycles, scheduler continues to filter 2, done pulses; the next start clears err.
- reset driven low mid-STREAM of filter 2 -> all outputs 0 immediately (asynchronous), state IDLE; a fresh start then completes normally.
